// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared types and helpers for the hazard/forwarding scoreboard.
//               Entry record layout, forward-select width, register-file
//               select encoding and the LOAD_LAT legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

   // The entry record carries a fixed-width destination field so one type
   // serves every AW up to this width. Narrower AW values are zero-extended.
   localparam int c_RD_MAX_W = 8;

   // Forward-select value meaning "read the register file".
   localparam int c_FWD_RF = 0;

   typedef struct packed {
      logic                  valid;
      logic [c_RD_MAX_W-1:0] rd;
      logic                  load;
   } hz_entry_t;

   // One select code per tracked entry plus the register-file code.
   function automatic int sel_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Load data must become forwardable at some tracked entry other than
   // the first.
   function automatic bit load_lat_ok(input int lat, input int depth);
      return (lat >= 1) && (lat <= depth - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_match_port.sv
`default_nettype none
// ============================================================================
// Module      : hz_match_port
// Description : Priority match of one source register against the in-flight
//               entry array. The lowest-index (youngest) valid entry with a
//               matching destination wins.
// Ports       : entries    - in-flight entry array (index 0 = youngest)
//               rs_addr    - source register address
//               rs_need    - the port really reads its source
//               sel        - 0 = register file, k+1 = forward from entry k
//               port_stall - youngest producer is a load whose data is not
//                            yet available
// Revision    : 1.0 - initial release
// ============================================================================
module hz_match_port
   import hazard_scoreboard_pkg::*;
#(
   parameter int DEPTH    = 3,
   parameter int AW       = 5,
   parameter int LOAD_LAT = 1,
   parameter int SELW     = 2
)(
   input  hz_entry_t        entries [DEPTH],
   input  logic [AW-1:0]    rs_addr,
   input  logic             rs_need,
   output logic [SELW-1:0]  sel,
   output logic             port_stall
);

   logic [c_RD_MAX_W-1:0] w_key;
   logic                  w_found;

   assign w_key = c_RD_MAX_W'(rs_addr);

   always_comb begin
      sel        = SELW'(c_FWD_RF);
      port_stall = 1'b0;
      w_found    = 1'b0;
      // Register 0 is hardwired zero and never has a producer.
      if (rs_need && (rs_addr != '0)) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (!w_found && entries[k].valid && (entries[k].rd == w_key)) begin
               w_found = 1'b1;
               // A load too young to forward blocks the port; older
               // matches must not be used because they hold stale data.
               if (entries[k].load && (k < LOAD_LAT)) begin
                  port_stall = 1'b1;
               end else begin
                  sel = SELW'(k + 1);
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Parametrised hazard/forwarding unit. Tracks register writes
//               in flight across DEPTH post-issue stages and produces the
//               per-read-port forward selects, the load-use issue stall and a
//               per-register busy vector.
// Ports       : Clk, Rst      - clock, asynchronous active-high reset
//               issue_*       - instruction presented by decode
//               rs_addr/need  - NRD packed source addresses / read enables
//               Stall         - global hold of every entry
//               Flush         - per-entry invalidate (beats capture/shift/hold)
//               fwd_sel       - NRD packed selects, SELW bits each
//               issue_stall   - load-use bubble request
//               busy          - bit r set while a valid entry targets r
// Options     : HZ_SCOREBOARD_STATS_EN adds saturating stat_lu_stalls and
//               stat_flushes counters as outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter  int NREG     = 32,
   parameter  int AW       = 5,
   parameter  int DEPTH    = 3,
   parameter  int NRD      = 2,
   parameter  int LOAD_LAT = 1,
   localparam int SELW     = sel_width(DEPTH)
)(
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 issue_valid,
   input  logic                 issue_we,
   input  logic                 issue_load,
   input  logic [AW-1:0]        issue_rd,
   input  logic [NRD*AW-1:0]    rs_addr,
   input  logic [NRD-1:0]       rs_need,
   input  logic                 Stall,
   input  logic [DEPTH-1:0]     Flush,
   output logic [NRD*SELW-1:0]  fwd_sel,
   output logic                 issue_stall,
`ifdef HZ_SCOREBOARD_STATS_EN
   output logic [31:0]          stat_lu_stalls,
   output logic [31:0]          stat_flushes,
`endif
   output logic [NREG-1:0]      busy
);

   generate
      if (!load_lat_ok(LOAD_LAT, DEPTH)) begin : g_bad_load_lat
         $error("hazard_scoreboard: LOAD_LAT must lie in 1..DEPTH-1");
      end
      if (AW > c_RD_MAX_W) begin : g_bad_aw
         $error("hazard_scoreboard: AW exceeds entry rd field width");
      end
   endgenerate

   hz_entry_t        r_entry [DEPTH];
   hz_entry_t        w_new_entry;
   logic [SELW-1:0]  w_sel [NRD];
   logic [NRD-1:0]   w_port_stall;
   logic             w_capture;
   logic [NREG-1:0]  w_busy;

   // ---------------------------------------------------------------------
   // Hazard detection, one matcher per read port
   // ---------------------------------------------------------------------
   generate
      for (genvar p = 0; p < NRD; p++) begin : g_port
         hz_match_port #(
            .DEPTH    (DEPTH),
            .AW       (AW),
            .LOAD_LAT (LOAD_LAT),
            .SELW     (SELW)
         ) u_match (
            .entries    (r_entry),
            .rs_addr    (rs_addr[p*AW +: AW]),
            .rs_need    (rs_need[p]),
            .sel        (w_sel[p]),
            .port_stall (w_port_stall[p])
         );
         assign fwd_sel[p*SELW +: SELW] = w_sel[p];
      end
   endgenerate

   // A stalled issue is not in flight; it becomes a bubble in entry 0.
   assign issue_stall = issue_valid & (|w_port_stall);

   assign w_capture   = issue_valid & issue_we & (issue_rd != '0) & ~issue_stall;
   assign w_new_entry = '{valid: w_capture,
                          rd:    c_RD_MAX_W'(issue_rd),
                          load:  issue_load};

   // ---------------------------------------------------------------------
   // Entry pipeline: Flush wins, otherwise shift unless Stall holds
   // ---------------------------------------------------------------------
   generate
      for (genvar k = 0; k < DEPTH; k++) begin : g_entry
         if (k == 0) begin : g_head
            always_ff @(posedge Clk or posedge Rst) begin
               if (Rst) begin
                  r_entry[0] <= '0;
               end else if (Flush[0]) begin
                  r_entry[0] <= '0;
               end else if (!Stall) begin
                  r_entry[0] <= w_new_entry;
               end
            end
         end else begin : g_tail
            always_ff @(posedge Clk or posedge Rst) begin
               if (Rst) begin
                  r_entry[k] <= '0;
               end else if (Flush[k]) begin
                  r_entry[k] <= '0;
               end else if (!Stall) begin
                  r_entry[k] <= r_entry[k-1];
               end
            end
         end
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Busy vector: decoded OR of every valid destination
   // ---------------------------------------------------------------------
   always_comb begin
      w_busy = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (r_entry[k].valid) begin
            w_busy[r_entry[k].rd[AW-1:0]] = 1'b1;
         end
      end
   end

   assign busy = w_busy;

`ifdef HZ_SCOREBOARD_STATS_EN
   // ---------------------------------------------------------------------
   // Saturating event counters
   // ---------------------------------------------------------------------
   logic [31:0] r_lu_stalls;
   logic [31:0] r_flushes;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_lu_stalls <= '0;
         r_flushes   <= '0;
      end else begin
         // Only count bubbles that are really inserted (not frozen by Stall).
         if (issue_stall && !Stall && (r_lu_stalls != '1)) begin
            r_lu_stalls <= r_lu_stalls + 32'd1;
         end
         if ((Flush != '0) && (r_flushes != '1)) begin
            r_flushes <= r_flushes + 32'd1;
         end
      end
   end

   assign stat_lu_stalls = r_lu_stalls;
   assign stat_flushes   = r_flushes;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard. A list-of-records
//               model of the in-flight writes predicts fwd_sel, issue_stall
//               and busy every cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

   localparam int NREG     = 32;
   localparam int AW       = 5;
   localparam int DEPTH    = 3;
   localparam int NRD      = 2;
   localparam int LOAD_LAT = 1;
   localparam int SELW     = 2;

   logic                 Clk = 1'b0;
   logic                 Rst;
   logic                 issue_valid, issue_we, issue_load;
   logic [AW-1:0]        issue_rd;
   logic [NRD*AW-1:0]    rs_addr;
   logic [NRD-1:0]       rs_need;
   logic                 Stall;
   logic [DEPTH-1:0]     Flush;
   logic [NRD*SELW-1:0]  fwd_sel;
   logic                 issue_stall;
   logic [NREG-1:0]      busy;
`ifdef HZ_SCOREBOARD_STATS_EN
   logic [31:0]          stat_lu_stalls, stat_flushes;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   bit run    = 1'b0;

   always #5 Clk = ~Clk;

   hazard_scoreboard #(
      .NREG(NREG), .AW(AW), .DEPTH(DEPTH), .NRD(NRD), .LOAD_LAT(LOAD_LAT)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .issue_valid (issue_valid),
      .issue_we    (issue_we),
      .issue_load  (issue_load),
      .issue_rd    (issue_rd),
      .rs_addr     (rs_addr),
      .rs_need     (rs_need),
      .Stall       (Stall),
      .Flush       (Flush),
      .fwd_sel     (fwd_sel),
      .issue_stall (issue_stall),
`ifdef HZ_SCOREBOARD_STATS_EN
      .stat_lu_stalls (stat_lu_stalls),
      .stat_flushes   (stat_flushes),
`endif
      .busy        (busy)
   );

   // ---------------------------------------------------------------------
   // Model: ordered list of in-flight writes, youngest first
   // ---------------------------------------------------------------------
   typedef struct packed {
      logic        v;
      logic [31:0] rd;
      logic        ld;
   } rec_t;

   rec_t               pipe  [DEPTH];
   rec_t               m_nxt [DEPTH];
   logic [NRD*SELW-1:0] exp_sel;
   logic               exp_stall;
   logic [NREG-1:0]    exp_busy;

   function automatic void m_eval(output logic [NRD*SELW-1:0] sel,
                                  output logic stall,
                                  output logic [NREG-1:0] bsy);
      logic any;
      sel = '0;
      any = 1'b0;
      bsy = '0;
      for (int p = 0; p < NRD; p++) begin
         int a;
         a = int'(rs_addr[p*AW +: AW]);
         if (rs_need[p] && a != 0) begin
            for (int k = 0; k < DEPTH; k++) begin
               if (pipe[k].v && pipe[k].rd == 32'(a)) begin
                  if (pipe[k].ld && k < LOAD_LAT) any = 1'b1;
                  else sel[p*SELW +: SELW] = SELW'(k + 1);
                  break;
               end
            end
         end
      end
      stall = any & issue_valid;
      for (int k = 0; k < DEPTH; k++)
         if (pipe[k].v) bsy[pipe[k].rd] = 1'b1;
   endfunction

   always_comb begin
      m_eval(exp_sel, exp_stall, exp_busy);
      m_nxt = pipe;
      if (!Stall) begin
         for (int k = DEPTH - 1; k > 0; k--) m_nxt[k] = pipe[k-1];
         m_nxt[0].v  = issue_valid & issue_we & (issue_rd != 0) & ~exp_stall;
         m_nxt[0].rd = 32'(issue_rd);
         m_nxt[0].ld = issue_load;
      end
      for (int k = 0; k < DEPTH; k++)
         if (Flush[k]) m_nxt[k].v = 1'b0;
   end

   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int k = 0; k < DEPTH; k++) pipe[k] <= '0;
      end else begin
         pipe <= m_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------
   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (run && !Rst) begin
         chk("model fwd_sel",     64'(fwd_sel),     64'(exp_sel));
         chk("model issue_stall", 64'(issue_stall), 64'(exp_stall));
         chk("model busy",        64'(busy),        64'(exp_busy));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------
   task automatic idle();
      issue_valid = 1'b0; issue_we = 1'b0; issue_load = 1'b0; issue_rd = '0;
      rs_addr = '0; rs_need = '0; Stall = 1'b0; Flush = '0;
   endtask

   task automatic issue(input logic ld, input logic [AW-1:0] rd);
      idle();
      issue_valid = 1'b1; issue_we = 1'b1; issue_load = ld; issue_rd = rd;
   endtask

   task automatic rd_only(input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                          input logic [1:0] need, input logic v);
      idle();
      issue_valid = v;
      rs_addr = {a1, a0};
      rs_need = need;
   endtask

   task automatic go();
      @(posedge Clk); #1;
   endtask

   task automatic mid();
      @(negedge Clk); #1;
   endtask

   // ---------------------------------------------------------------------
   // Directed scenarios
   // ---------------------------------------------------------------------
   initial begin
      Rst = 1'b1;
      idle();
      repeat (2) @(posedge Clk);
      #1;
      chk("reset fwd_sel",     64'(fwd_sel),     64'h0);
      chk("reset issue_stall", 64'(issue_stall), 64'h0);
      chk("reset busy",        64'(busy),        64'h0);
      Rst = 1'b0;
      run = 1'b1;

      // ALU chain: producer ages through entries 0,1,2 then retires
      issue(1'b0, 5'd5); go();
      rd_only(5'd0, 5'd5, 2'b01, 1'b0);
      mid(); chk("alu chain age0", 64'(fwd_sel), 64'd1); go();
      mid(); chk("alu chain age1", 64'(fwd_sel), 64'd2); go();
      mid(); chk("alu chain age2", 64'(fwd_sel), 64'd3); go();
      mid(); chk("alu chain retired", 64'(fwd_sel), 64'd0); go();

      // Load-use: one bubble, then forward from entry 1 on port 1
      issue(1'b1, 5'd7); go();
      rd_only(5'd7, 5'd0, 2'b10, 1'b1);
      mid(); chk("load-use stall", 64'(issue_stall), 64'd1);
             chk("load-use sel",   64'(fwd_sel),     64'd0); go();
      mid(); chk("load-use stall cleared", 64'(issue_stall), 64'd0);
             chk("load-use fwd",   64'(fwd_sel),     64'h8); go();

      // Youngest producer wins
      issue(1'b0, 5'd3); go();
      issue(1'b0, 5'd3); go();
      rd_only(5'd0, 5'd3, 2'b01, 1'b0);
      mid(); chk("youngest wins", 64'(fwd_sel), 64'd1); go();

      // Hold under Stall, then flush entry 1 while holding
      idle(); go(); go(); go();
      issue(1'b0, 5'd12); go();
      idle(); go();
      rd_only(5'd0, 5'd12, 2'b01, 1'b0);
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mid(); chk("hold sel",  64'(fwd_sel), 64'd2);
                chk("hold busy", 64'(busy),    64'h1000); go();
      end
      Flush = 3'b010;
      go();
      Flush = 3'b000;
      mid(); chk("flush sel",  64'(fwd_sel), 64'd0);
             chk("flush busy", 64'(busy),    64'h0); go();
      Stall = 1'b0;

      // Zero register and unneeded port
      issue(1'b0, 5'd0); go();
      rd_only(5'd0, 5'd0, 2'b01, 1'b1);
      mid(); chk("r0 sel",   64'(fwd_sel),     64'd0);
             chk("r0 stall", 64'(issue_stall), 64'd0);
             chk("r0 busy",  64'(busy),        64'h0); go();
      issue(1'b1, 5'd9); go();
      rd_only(5'd0, 5'd9, 2'b00, 1'b1);
      mid(); chk("unneeded port stall", 64'(issue_stall), 64'd0);
             chk("unneeded port sel",   64'(fwd_sel),     64'd0); go();

      // Flush of entry 0 beats the capture of a new issue
      issue(1'b0, 5'd20);
      Flush = 3'b001;
      go();
      idle();
      mid(); chk("flush beats capture", 64'(busy), 64'h200); go();

      // Reset while three writes are in flight
      idle(); go(); go(); go();
      issue(1'b0, 5'd1); go();
      issue(1'b0, 5'd2); go();
      issue(1'b0, 5'd3); go();
      rd_only(5'd1, 5'd2, 2'b11, 1'b0);
      mid(); chk("full busy", 64'(busy),    64'hE);
             chk("full sel",  64'(fwd_sel), 64'hE);
      Rst = 1'b1;
      #1;
      chk("async reset busy",    64'(busy),        64'h0);
      chk("async reset fwd_sel", 64'(fwd_sel),     64'h0);
      chk("async reset stall",   64'(issue_stall), 64'h0);
      go();
      mid();
      Rst = 1'b0;
      idle(); go();
      mid(); chk("post-reset busy", 64'(busy), 64'h0); go();

      run = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
